auth_msg_arbiter: RTL and testbench
===================================

# auth_msg_arbiter

Synthesisable, parametrised successor to the single-channel PD/DEBUG driver model. It buffers authentication request messages from NUM_CH requesters (channel 0 = PD, channel 1 = DEBUG, more when scaled) in per-channel FIFOs. It arbitrates round-robin and presents one message at a time to the authentication controller. It acknowledges the controller's reply with Ack_in_driver and routes that reply back to the channel that owns the transaction.

## Interface
- MSG_LEN, 2048: message width in bits (header + payload).
- NUM_CH, 2: number of requester channels, 2..8.
- FIFO_DEPTH, 4: entries per channel FIFO, power of two, >= 2.
- TIMEOUT_CYC, 1024: watchdog limit in cycles. Only used with the watchdog compiled in.
- CH_W and LVL_W are derived: CH_W = max(1, clog2(NUM_CH)); LVL_W = clog2(FIFO_DEPTH) + 1.

- clk  in  1  single clock, all state on the rising edge
- reset  in  1  asynchronous, active-high
- ch_msg_valid  in  NUM_CH  per-channel push request
- ch_msg_data  in  NUM_CH*MSG_LEN  per-channel message; channel i occupies slice [i*MSG_LEN +: MSG_LEN]
- ch_msg_ready  out  NUM_CH  FIFO i not full
- ch_level  out  NUM_CH*LVL_W  per-channel FIFO occupancy
- auth_msg_in  out  MSG_LEN  message presented to the controller
- msg_valid  out  1  auth_msg_in valid
- msg_ch  out  CH_W  channel owning the current transaction
- msg_accept  in  1  controller takes auth_msg_in
- auth_msg_out  in  MSG_LEN  controller reply
- auth_msg_ready  in  1  auth_msg_out valid
- Ack_in_driver  out  1  one-cycle acknowledge of the reply
- rsp_valid  out  NUM_CH  one-hot, one-cycle reply strobe to the owning channel
- rsp_data  out  MSG_LEN  registered copy of the reply
- timeout_err  out  1  one-cycle watchdog pulse

## Operation
- Push: at an edge where ch_msg_valid[i] & ch_msg_ready[i], the message is written into FIFO i.
  - ch_msg_ready[i] depends only on FIFO i not being full. There is no bypass and no push-on-full, even in a cycle where a pop happens.
- FSM has three states: IDLE, SEND, WAIT_RSP.
  - IDLE: if any FIFO is non-empty, grant the first non-empty channel at or after rr_ptr (searching upward and wrapping). Load that FIFO's head into auth_msg_in, set msg_ch, go to SEND.
  - SEND: msg_valid = 1. auth_msg_in and msg_ch are held stable. When msg_accept = 1, pop the granted FIFO, set rr_ptr = grant+1 (mod NUM_CH), go to WAIT_RSP.
  - WAIT_RSP: when auth_msg_ready = 1, capture auth_msg_out into rsp_data, pulse rsp_valid[msg_ch] and Ack_in_driver on the next cycle, go to IDLE.
- auth_msg_ready in IDLE or SEND (unsolicited reply): Ack_in_driver still pulses, rsp_valid stays 0, rsp_data is unchanged, state is unchanged.
- auth_msg_ready held high for several cycles gives one Ack per cycle it is high, matching the driver model. rsp_valid pulses only for the first of those cycles.
- Every FIFO pointer wraps modulo FIFO_DEPTH. Occupancy ranges from 0 to FIFO_DEPTH inclusive.

## Timing
- Reset values: FSM = IDLE, rr_ptr = 0, all FIFOs empty, ch_msg_ready = all 1, ch_level = 0, auth_msg_in = 0, msg_valid = 0, msg_ch = 0, Ack_in_driver = 0, rsp_valid = 0, rsp_data = 0, timeout_err = 0.
- All outputs are registered except ch_msg_ready and ch_level, which are decoded directly from the FIFO pointers.
- Latency:
  - Push at edge k into an idle block with all FIFOs empty: msg_valid is high after edge k+1.
  - auth_msg_ready sampled at edge k: Ack_in_driver and rsp_valid are high after edge k+1, for one cycle.
- Back-to-back: after a reply, IDLE spends one cycle before the next msg_valid.
- Reset asserted mid-transaction: everything returns to reset values immediately. In-flight and queued messages are discarded.

## Configuration
- AUTH_MSG_TIMEOUT_EN defined:
  - A counter runs while in SEND or WAIT_RSP and clears on every state change.
  - When it reaches TIMEOUT_CYC-1, timeout_err pulses for one cycle and the FSM returns to IDLE.
  - A timeout in SEND leaves the message in its FIFO and advances rr_ptr past that channel.
  - A timeout in WAIT_RSP abandons the transaction with no rsp_valid.
- AUTH_MSG_TIMEOUT_EN undefined: no counter exists, the FSM waits indefinitely, and timeout_err is tied to 0.

## Test plan
- Reset then a single PD push of {16'h0101, payload}, msg_accept one cycle after msg_valid, auth_msg_ready 3 cycles later -> auth_msg_in matches, msg_ch = 0, Ack_in_driver and rsp_valid = 2'b01 pulse once, rsp_data = auth_msg_out.
- Both channels push 3 messages each while msg_accept is held at 1 and auth_msg_ready answers immediately -> grant order 0,1,0,1,0,1; ch_level reaches 3 then drains to 0.
- Push 5 messages into channel 1 (FIFO_DEPTH = 4) with msg_accept held at 0 -> ch_msg_ready[1] = 0 after the 4th push, the 5th push is not accepted, ch_level[1] = 4.
- Unsolicited auth_msg_ready pulse in IDLE -> Ack_in_driver = 1 for one cycle, rsp_valid = 0, rsp_data unchanged.
- Reset asserted while in WAIT_RSP with FIFO 0 holding 2 entries -> all outputs return to reset values the same cycle, ch_level = 0.
- With AUTH_MSG_TIMEOUT_EN and TIMEOUT_CYC = 16, msg_accept never asserted -> timeout_err pulses 16 cycles after msg_valid rises, ch_level[0] is unchanged, the next grant goes to channel 1 if it is non-empty.

Source files
------------

// File: rtl/auth_msg_arbiter.sv
// auth_msg_arbiter
//
// Buffers authentication request messages from NUM_CH requesters in per-channel
// FIFOs, arbitrates round-robin, and presents one message at a time to the
// authentication controller. The controller's reply is acknowledged on
// Ack_in_driver and routed back to the channel that owns the transaction.
//
// Optional feature: define AUTH_MSG_TIMEOUT_EN to compile in a watchdog that
// aborts a transaction stuck in SEND or WAIT_RSP after TIMEOUT_CYC cycles.
// Without the macro no counter exists and timeout_err stays 0.
//
// Ports:
//   clk             clock, all state on the rising edge
//   reset           asynchronous active-high reset
//   ch_msg_valid    per-channel push request
//   ch_msg_data     per-channel message, channel i at [i*MSG_LEN +: MSG_LEN]
//   ch_msg_ready    FIFO i not full (combinational from pointers)
//   ch_level        per-channel FIFO occupancy (combinational from pointers)
//   auth_msg_in     message presented to the controller
//   msg_valid       auth_msg_in valid
//   msg_ch          channel owning the current transaction
//   msg_accept      controller takes auth_msg_in
//   auth_msg_out    controller reply
//   auth_msg_ready  auth_msg_out valid
//   Ack_in_driver   one-cycle acknowledge per cycle auth_msg_ready is high
//   rsp_valid       one-hot reply strobe to the owning channel
//   rsp_data        registered copy of the reply
//   timeout_err     one-cycle watchdog pulse

module auth_msg_arbiter #(
    parameter int unsigned MSG_LEN     = 2048,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CH_W  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           ch_msg_valid,
    input  logic [NUM_CH*MSG_LEN-1:0]   ch_msg_data,
    output logic [NUM_CH-1:0]           ch_msg_ready,
    output logic [NUM_CH*LVL_W-1:0]     ch_level,
    output logic [MSG_LEN-1:0]          auth_msg_in,
    output logic                        msg_valid,
    output logic [CH_W-1:0]             msg_ch,
    input  logic                        msg_accept,
    input  logic [MSG_LEN-1:0]          auth_msg_out,
    input  logic                        auth_msg_ready,
    output logic                        Ack_in_driver,
    output logic [NUM_CH-1:0]           rsp_valid,
    output logic [MSG_LEN-1:0]          rsp_data,
    output logic                        timeout_err
);

    localparam int unsigned AW = LVL_W - 1;

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("auth_msg_arbiter: NUM_CH must be in 2..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("auth_msg_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("auth_msg_arbiter: TIMEOUT_CYC must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StSend, StWaitRsp} state_e;

    state_e state_q, state_d;

    // FIFO storage and pointers; pointers carry one extra wrap bit so that
    // full and empty are distinguishable.
    logic [MSG_LEN-1:0] mem_q [NUM_CH][FIFO_DEPTH];
    logic [LVL_W-1:0]   wr_ptr_q [NUM_CH];
    logic [LVL_W-1:0]   rd_ptr_q [NUM_CH];
    logic [LVL_W-1:0]   level    [NUM_CH];
    logic [NUM_CH-1:0]  empty;
    logic [NUM_CH-1:0]  full;
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  pop;

    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [MSG_LEN-1:0] auth_msg_in_q, auth_msg_in_d;
    logic               msg_valid_q, msg_valid_d;
    logic [CH_W-1:0]    msg_ch_q, msg_ch_d;
    logic               ack_q;
    logic [NUM_CH-1:0]  rsp_valid_q, rsp_valid_d;
    logic [MSG_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               timeout_err_q, timeout_err_d;

    logic               found;
    logic [CH_W-1:0]    grant;
    logic [CH_W-1:0]    next_ch;
    int unsigned        idx;
    logic               tmo_hit;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign level[i]                     = wr_ptr_q[i] - rd_ptr_q[i];
        assign empty[i]                     = (wr_ptr_q[i] == rd_ptr_q[i]);
        assign full[i]                      = (level[i] == LVL_W'(FIFO_DEPTH));
        assign push[i]                      = ch_msg_valid[i] & ~full[i];
        assign ch_msg_ready[i]              = ~full[i];
        assign ch_level[i*LVL_W +: LVL_W]   = level[i];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= ch_msg_data[i*MSG_LEN +: MSG_LEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
        end
    end

    // Round-robin search: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx = (32'(rr_ptr_q) + 32'(j)) % NUM_CH;
            if (!found && !empty[CH_W'(idx)]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

    assign next_ch = (msg_ch_q == CH_W'(NUM_CH - 1)) ? '0 : msg_ch_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        auth_msg_in_d = auth_msg_in_q;
        msg_valid_d   = msg_valid_q;
        msg_ch_d      = msg_ch_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        timeout_err_d = 1'b0;
        pop           = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    auth_msg_in_d = mem_q[grant][rd_ptr_q[grant][AW-1:0]];
                    msg_ch_d      = grant;
                    msg_valid_d   = 1'b1;
                    state_d       = StSend;
                end
            end
            StSend: begin
                if (msg_accept) begin
                    pop[msg_ch_q] = 1'b1;
                    rr_ptr_d      = next_ch;
                    msg_valid_d   = 1'b0;
                    state_d       = StWaitRsp;
                end else if (tmo_hit) begin
                    // Message stays queued; skip this channel next time round.
                    rr_ptr_d      = next_ch;
                    msg_valid_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            StWaitRsp: begin
                if (auth_msg_ready) begin
                    rsp_data_d            = auth_msg_out;
                    rsp_valid_d[msg_ch_q] = 1'b1;
                    state_d               = StIdle;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            auth_msg_in_q <= '0;
            msg_valid_q   <= 1'b0;
            msg_ch_q      <= '0;
            ack_q         <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            auth_msg_in_q <= auth_msg_in_d;
            msg_valid_q   <= msg_valid_d;
            msg_ch_q      <= msg_ch_d;
            // Every reply strobe is acknowledged, solicited or not.
            ack_q         <= auth_msg_ready;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef AUTH_MSG_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] tmo_cnt_q;

    // Counts cycles spent in the current SEND/WAIT_RSP visit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q || state_q == StIdle) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q != StIdle) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign auth_msg_in   = auth_msg_in_q;
    assign msg_valid     = msg_valid_q;
    assign msg_ch        = msg_ch_q;
    assign Ack_in_driver = ack_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_auth_msg_arbiter.sv
// Directed testbench for auth_msg_arbiter (MSG_LEN=64, NUM_CH=2, FIFO_DEPTH=4,
// TIMEOUT_CYC=16). Inputs are driven and outputs sampled 1 time unit after
// each rising edge.

module tb_auth_msg_arbiter;

    localparam int unsigned MSG_LEN = 64;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CH_W    = 1;
    localparam int unsigned LVL_W   = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         ch_msg_valid;
    logic [NUM_CH*MSG_LEN-1:0] ch_msg_data;
    logic [NUM_CH-1:0]         ch_msg_ready;
    logic [NUM_CH*LVL_W-1:0]   ch_level;
    logic [MSG_LEN-1:0]        auth_msg_in;
    logic                      msg_valid;
    logic [CH_W-1:0]           msg_ch;
    logic                      msg_accept;
    logic [MSG_LEN-1:0]        auth_msg_out;
    logic                      auth_msg_ready;
    logic                      Ack_in_driver;
    logic [NUM_CH-1:0]         rsp_valid;
    logic [MSG_LEN-1:0]        rsp_data;
    logic                      timeout_err;

    int total = 0;
    int bad   = 0;

    auth_msg_arbiter #(
        .MSG_LEN    (MSG_LEN),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_msg_valid  (ch_msg_valid),
        .ch_msg_data   (ch_msg_data),
        .ch_msg_ready  (ch_msg_ready),
        .ch_level      (ch_level),
        .auth_msg_in   (auth_msg_in),
        .msg_valid     (msg_valid),
        .msg_ch        (msg_ch),
        .msg_accept    (msg_accept),
        .auth_msg_out  (auth_msg_out),
        .auth_msg_ready(auth_msg_ready),
        .Ack_in_driver (Ack_in_driver),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LVL_W-1:0] lvl(input int ch);
        return ch_level[ch*LVL_W +: LVL_W];
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_msg_valid"}, 64'(msg_valid), 64'd0);
        check({tag, "_ready"}, 64'(ch_msg_ready), 64'h3);
        check({tag, "_level"}, 64'(ch_level), 64'd0);
        check({tag, "_auth_msg_in"}, auth_msg_in, 64'd0);
        check({tag, "_msg_ch"}, 64'(msg_ch), 64'd0);
        check({tag, "_ack"}, 64'(Ack_in_driver), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, rsp_data, 64'd0);
        check({tag, "_timeout"}, 64'(timeout_err), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    logic [CH_W-1:0]    g_ch  [6];
    logic [MSG_LEN-1:0] g_dat [6];
    int                 ng, rsp0, rsp1, max1, rise_w, tmo_w, tmo_lvl0, seen_tmo;

    initial begin
        reset          = 1'b1;
        ch_msg_valid   = '0;
        ch_msg_data    = '0;
        msg_accept     = 1'b0;
        auth_msg_out   = '0;
        auth_msg_ready = 1'b0;
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;
        step();

        // ---- Single PD transaction ----
        ch_msg_valid = 2'b01;
        ch_msg_data  = {64'd0, 16'h0101, 48'hAAAA_BBBB_CCCC};
        step();
        ch_msg_valid = 2'b00;
        check("t1_level_after_push", 64'(lvl(0)), 64'd1);
        check("t1_valid_not_yet", 64'(msg_valid), 64'd0);
        step();
        check("t1_msg_valid", 64'(msg_valid), 64'd1);
        check("t1_auth_msg_in", auth_msg_in, {16'h0101, 48'hAAAA_BBBB_CCCC});
        check("t1_msg_ch", 64'(msg_ch), 64'd0);
        msg_accept = 1'b1;
        step();
        msg_accept = 1'b0;
        check("t1_valid_drop", 64'(msg_valid), 64'd0);
        check("t1_level_popped", 64'(lvl(0)), 64'd0);
        step();
        step();
        auth_msg_ready = 1'b1;
        auth_msg_out   = 64'h1234_5678_9ABC_DEF0;
        step();
        auth_msg_ready = 1'b0;
        check("t1_ack", 64'(Ack_in_driver), 64'd1);
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_rsp_data", rsp_data, 64'h1234_5678_9ABC_DEF0);
        step();
        check("t1_ack_once", 64'(Ack_in_driver), 64'd0);
        check("t1_rsp_once", 64'(rsp_valid), 64'd0);

        // ---- Unsolicited reply in IDLE ----
        auth_msg_ready = 1'b1;
        auth_msg_out   = 64'hBAD0_BAD0;
        step();
        auth_msg_ready = 1'b0;
        check("idle_unsol_ack", 64'(Ack_in_driver), 64'd1);
        check("idle_unsol_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_unsol_rsp_data", rsp_data, 64'h1234_5678_9ABC_DEF0);
        step();
        check("idle_unsol_ack_once", 64'(Ack_in_driver), 64'd0);
        check("idle_unsol_no_send", 64'(msg_valid), 64'd0);

        // ---- Two channels, 3 messages each, round-robin ----
        do_reset();
        ng = 0; rsp0 = 0; rsp1 = 0; max1 = 0;
        msg_accept     = 1'b1;
        auth_msg_ready = 1'b1;
        auth_msg_out   = 64'h5555;
        for (int w = 0; w < 60; w++) begin
            if (w < 3) begin
                ch_msg_valid = 2'b11;
                ch_msg_data  = {64'hB000 + 64'(w), 64'hA000 + 64'(w)};
            end else begin
                ch_msg_valid = 2'b00;
            end
            if (msg_valid && ng < 6) begin
                g_ch[ng]  = msg_ch;
                g_dat[ng] = auth_msg_in;
                ng++;
            end
            if (rsp_valid[0]) rsp0++;
            if (rsp_valid[1]) rsp1++;
            if (int'(lvl(1)) > max1) max1 = int'(lvl(1));
            step();
        end
        msg_accept     = 1'b0;
        auth_msg_ready = 1'b0;
        check("rr_grant_count", 64'(ng), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_grant_ch%0d", k), 64'(g_ch[k]), 64'(k % 2));
            check($sformatf("rr_grant_data%0d", k), g_dat[k],
                  (k % 2 == 0) ? 64'hA000 + 64'(k / 2) : 64'hB000 + 64'(k / 2));
        end
        check("rr_rsp_ch0", 64'(rsp0), 64'd3);
        check("rr_rsp_ch1", 64'(rsp1), 64'd3);
        check("rr_level_peak", 64'(max1), 64'd3);
        check("rr_level_drained", 64'(ch_level), 64'd0);

        // ---- Fill channel 1 past depth ----
        for (int w = 0; w < 4; w++) begin
            ch_msg_valid = 2'b10;
            ch_msg_data  = {64'hC000 + 64'(w), 64'd0};
            step();
        end
        check("full_ready1", 64'(ch_msg_ready), 64'h1);
        check("full_level1", 64'(lvl(1)), 64'd4);
        ch_msg_data = {64'hC004, 64'd0};
        step();
        check("full_5th_rejected", 64'(lvl(1)), 64'd4);
        check("full_head_msg", auth_msg_in, 64'hC000);
        check("full_head_ch", 64'(msg_ch), 64'd1);
        // Pop while full: push must still be refused at this edge.
        msg_accept = 1'b1;
        step();
        msg_accept   = 1'b0;
        ch_msg_valid = 2'b00;
        check("full_no_push_on_pop", 64'(lvl(1)), 64'd3);

        // ---- Reply, then unsolicited reply while in SEND ----
        auth_msg_ready = 1'b1;
        auth_msg_out   = 64'hCAFE;
        step();
        auth_msg_ready = 1'b0;
        check("ch1_rsp_valid", 64'(rsp_valid), 64'h2);
        check("ch1_rsp_data", rsp_data, 64'hCAFE);
        step();
        check("b2b_valid", 64'(msg_valid), 64'd1);
        check("b2b_msg", auth_msg_in, 64'hC001);
        auth_msg_ready = 1'b1;
        auth_msg_out   = 64'hDEAD;
        step();
        auth_msg_ready = 1'b0;
        check("send_unsol_ack", 64'(Ack_in_driver), 64'd1);
        check("send_unsol_rsp_valid", 64'(rsp_valid), 64'd0);
        check("send_unsol_rsp_data", rsp_data, 64'hCAFE);
        check("send_unsol_still_send", 64'(msg_valid), 64'd1);

        // ---- Reset during WAIT_RSP with FIFO 0 holding 2 entries ----
        do_reset();
        for (int w = 0; w < 3; w++) begin
            ch_msg_valid = 2'b01;
            ch_msg_data  = {64'd0, 64'hD000 + 64'(w)};
            step();
        end
        ch_msg_valid = 2'b00;
        msg_accept   = 1'b1;
        step();
        msg_accept = 1'b0;
        check("mid_level0", 64'(lvl(0)), 64'd2);
        check("mid_auth_msg_in", auth_msg_in, 64'hD000);
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        step();
        reset = 1'b0;
        step();
        step();
        check("post_rst_idle", 64'(msg_valid), 64'd0);

`ifdef AUTH_MSG_TIMEOUT_EN
        // ---- Watchdog in SEND ----
        ch_msg_valid = 2'b11;
        ch_msg_data  = {64'hE001, 64'hE000};
        step();
        ch_msg_valid = 2'b00;
        rise_w = -1; tmo_w = -1; tmo_lvl0 = -1;
        for (int w = 0; w < 40; w++) begin
            if (msg_valid && rise_w < 0) rise_w = w;
            if (timeout_err && tmo_w < 0) begin
                tmo_w    = w;
                tmo_lvl0 = int'(lvl(0));
                break;
            end
            step();
        end
        check("tmo_seen", 64'(tmo_w >= 0), 64'd1);
        check("tmo_delay", 64'(tmo_w - rise_w), 64'd16);
        check("tmo_level0_kept", 64'(tmo_lvl0), 64'd1);
        step();
        check("tmo_pulse_once", 64'(timeout_err), 64'd0);
        check("tmo_next_grant_valid", 64'(msg_valid), 64'd1);
        check("tmo_next_grant_ch", 64'(msg_ch), 64'd1);
        check("tmo_next_grant_msg", auth_msg_in, 64'hE001);
`else
        // ---- No watchdog: SEND is held indefinitely ----
        ch_msg_valid = 2'b01;
        ch_msg_data  = {64'd0, 64'hF000};
        step();
        ch_msg_valid = 2'b00;
        seen_tmo = 0;
        for (int w = 0; w < 30; w++) begin
            if (timeout_err) seen_tmo = 1;
            step();
        end
        check("no_wdog_timeout_err", 64'(seen_tmo), 64'd0);
        check("no_wdog_still_send", 64'(msg_valid), 64'd1);
        check("no_wdog_level0", 64'(lvl(0)), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
